spi_sequencer: RTL and testbench
================================

# spi_sequencer

Multi-requester transaction sequencer in front of the `master` SPI engine. It arbitrates round-robin between `NREQ` clients, each requesting a multi-byte transfer to its own slave-select code. It feeds the granted client's bytes to the engine one strobe at a time and returns every received byte to that client. A per-byte watchdog aborts a transfer if the engine never reports completion.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `GAP`, 8'd0: idle cycles inserted between consecutive bytes of one transfer.
- `TIMEOUT`, 16'd1000: cycles allowed from strobe to `m_ready_i` before abort.
- `Clk_i` in 1: clock; all state on rising edge.
- `Rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in NREQ: level request per client; sampled only in IDLE.
- `len_i` in NREQ×4: byte count per client, sampled at grant; 0 encodes 16.
- `ss_i` in NREQ×2: slave-select code per client.
- `tx_data_i` in NREQ×8: next byte to send per client.
- `tx_pop_o` out NREQ: one-hot pulse; the client's `tx_data_i` was consumed this cycle.
- `grant_o` out NREQ: one-hot; high from grant through DONE.
- `rx_data_o` out 8: last received byte; shared by all clients.
- `rx_valid_o` out NREQ: one-hot pulse; `rx_data_o` is valid for that client.
- `done_o` out NREQ: one-hot end-of-transfer pulse.
- `err_o` out NREQ: one-hot pulse coincident with `done_o` on timeout abort.
- `m_strobe_o` out 1: strobe to the engine.
- `m_ss_o` out 2: slave-select to the engine.
- `m_toXmit_o` out 8: byte to the engine.
- `m_busy_i` in 1: engine busy.
- `m_ready_i` in 1: engine byte-complete pulse.
- `m_rcvd_i` in 8: engine received byte.

## Operation
- **Reset values:** state IDLE, rr pointer 0, every output 0.
- **IDLE:** if any `req_i` is set, pick the first requester at or after the rr pointer (wrapping).
  - Register `grant_o`, the granted index `g`, `remaining = len_i[g]` (0 loads 16), and `ss_i[g]`.
  - Go to LOAD.
- **LOAD (1 cycle):**
  - Drive `m_strobe_o=1`, `m_toXmit_o=tx_data_i[g]`, `m_ss_o=ss_q`, `tx_pop_o[g]=1`.
  - Clear the watchdog and go to WAIT.
- **WAIT:** the watchdog increments each cycle.
  - On `m_ready_i`: register `rx_data_o=m_rcvd_i`, pulse `rx_valid_o[g]` the next cycle, and decrement `remaining`. Then:
    - if `remaining` was 1, go to DONE;
    - else if `GAP==0`, go to LOAD;
    - else go to GAP.
  - If the watchdog reaches `TIMEOUT` with no `m_ready_i`, set the abort flag and go to DONE.
  - If `m_ready_i` and the timeout fall in the same cycle, `m_ready_i` wins.
- **GAP:** count `GAP` cycles, then go to LOAD.
- **DONE (1 cycle):**
  - Pulse `done_o[g]`, plus `err_o[g]` if aborted.
  - Set rr pointer to (g+1) mod NREQ, clear `grant_o`, return to IDLE.
- **Requests:**
  - A client must drop `req_i` no later than the cycle after its `done_o`; a request still high in IDLE is re-arbitrated fairly.
  - A `req_i` change during a transfer has no effect on that transfer.
- **Outside LOAD:** `m_strobe_o=0`; `m_ss_o`/`m_toXmit_o` hold their last values.
- **`m_busy_i`:** used only for a check. `m_busy_i` high in IDLE or LOAD is a protocol error; a simulation assertion flags it and the RTL ignores it.
- **Reset mid-transfer:** everything returns to reset values immediately. No `done_o` is emitted.

## Timing
- `req_i` seen in IDLE at cycle 0 → `grant_o` at cycle 1 → strobe at cycle 1. LOAD is entered the cycle after grant, so the strobe is combinational on state==LOAD.
- `m_ready_i` at cycle t:
  - `rx_valid_o`/`rx_data_o` at t+1;
  - next strobe at t+1 (`GAP=0`) or t+1+GAP;
  - `done_o` at t+1 for the last byte.
- Back-to-back transfers: earliest next grant is the cycle after DONE.
- `remaining` is 5 bits; the watchdog is 16 bits and saturates.

## Structure
- Package `spi_seq_pkg`:
  - state enum `seq_state_e` {IDLE, LOAD, WAIT, GAP, DONE};
  - `LEN_W=4`, `SS_W=2`, `DATA_W=8`.
- One sub-module `rr_arbiter`: parameterised NREQ, combinational pick from request vector plus pointer, one-hot grant and index out.
- Top level instantiates the arbiter, the FSM, the counters and the output registers. The engine is connected externally via the `SPIctrl` signals.

## Test plan
- **Single byte:** client 0 `len=1`, `ss=2'd1`, `tx=8'hA5`; slave loopback returns `8'h3C`.
  - Expect one strobe with `toXmit=A5`, `ss=1`.
  - Expect `rx_valid_o=4'b0001` with `rx_data_o=3C`, then `done_o[0]`.
- **Multi-byte, `GAP=2`:** client 2 `len=3`.
  - Expect exactly 3 `tx_pop_o[2]` pulses.
  - Expect strobes spaced exactly 3 cycles after each `m_ready_i`.
  - Expect 3 `rx_valid_o[2]` pulses, then `done_o[2]`.
- **Round-robin fairness:** all four clients request `len=1` and hold `req_i` high through one grant each.
  - Expect grant order 0,1,2,3; after re-request, expect the order to continue from 0.
- **Length 0:** client 1 `len=0`.
  - Expect 16 strobes, 16 `rx_valid_o[1]`, one `done_o[1]`.
- **Timeout:** `TIMEOUT=16'd50`; `m_ready_i` held low.
  - Expect `done_o[k]` and `err_o[k]` exactly 51 cycles after the strobe; no `rx_valid_o`; FSM returns to IDLE.
- **Reset mid-transfer:** assert `Rst_ni` low during WAIT of a 4-byte transfer.
  - Expect all outputs 0 the same cycle; after release, a new request completes normally from rr pointer 0.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and widths for the SPI transaction sequencer.
// Imported by the arbiter and the top-level sequencer.
package spi_seq_pkg;

   localparam int LEN_W  = 4;
   localparam int SS_W   = 2;
   localparam int DATA_W = 8;
   localparam int REM_W  = LEN_W + 1;
   localparam int WD_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_GAP,
      S_DONE
   } seq_state_e;

   // A zero length field means the maximum transfer of 2**LEN_W bytes.
   function automatic logic [REM_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
      return (len == '0) ? REM_W'(1 << LEN_W) : REM_W'(len);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int  NREQ  = 4,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      // Scan farthest offset first so the nearest request to ptr overwrites the rest.
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = IDX_W'((int'(ptr) + i) % NREQ);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_sequencer.sv
// Round-robin multi-client transaction sequencer driving a byte-wide SPI master engine,
// with a per-byte watchdog that aborts a transfer when the engine never completes.
module spi_sequencer
   import spi_seq_pkg::*;
#(
   parameter int          NREQ    = 4,
   parameter logic [7:0]  GAP     = 8'd0,
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic                     Clk_i,
   input  logic                     Rst_ni,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ*LEN_W-1:0]    len_i,
   input  logic [NREQ*SS_W-1:0]     ss_i,
   input  logic [NREQ*DATA_W-1:0]   tx_data_i,
   output logic [NREQ-1:0]          tx_pop_o,
   output logic [NREQ-1:0]          grant_o,
   output logic [DATA_W-1:0]        rx_data_o,
   output logic [NREQ-1:0]          rx_valid_o,
   output logic [NREQ-1:0]          done_o,
   output logic [NREQ-1:0]          err_o,
   output logic                     m_strobe_o,
   output logic [SS_W-1:0]          m_ss_o,
   output logic [DATA_W-1:0]        m_toXmit_o,
   input  logic                     m_busy_i,
   input  logic                     m_ready_i,
   input  logic [DATA_W-1:0]        m_rcvd_i
);

   localparam int IDX_W = $clog2(NREQ);

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, gidx_q;
   logic [REM_W-1:0]  rem_q;
   logic [SS_W-1:0]   ss_q, last_ss_q;
   logic [DATA_W-1:0] last_tx_q;
   logic [WD_W-1:0]   wd_q;
   logic [7:0]        gap_q;
   logic              abort_q;

   logic [NREQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic              wd_hit;

   logic [DATA_W-1:0] tx_arr  [NREQ];
   logic [LEN_W-1:0]  len_arr [NREQ];
   logic [SS_W-1:0]   ss_arr  [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign tx_arr[i]  = tx_data_i[i*DATA_W +: DATA_W];
      assign len_arr[i] = len_i[i*LEN_W +: LEN_W];
      assign ss_arr[i]  = ss_i[i*SS_W +: SS_W];
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_i),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // The abort fires on the cycle whose increment would make the watchdog reach TIMEOUT.
   assign wd_hit = ({1'b0, wd_q} + 17'd1) >= {1'b0, TIMEOUT};

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (arb_valid) state_d = S_LOAD;
         S_LOAD: state_d = S_WAIT;
         S_WAIT: begin
            if (m_ready_i) begin
               if (rem_q == REM_W'(1)) state_d = S_DONE;
               else if (GAP == 8'd0)   state_d = S_LOAD;
               else                    state_d = S_GAP;
            end else if (wd_hit) begin
               state_d = S_DONE;
            end
         end
         S_GAP:  if (gap_q == GAP - 8'd1) state_d = S_LOAD;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign m_strobe_o = (state_q == S_LOAD);
   assign tx_pop_o   = m_strobe_o ? grant_o : '0;
   assign done_o     = (state_q == S_DONE) ? grant_o : '0;
   assign err_o      = abort_q ? done_o : '0;
   assign m_ss_o     = m_strobe_o ? ss_q : last_ss_q;
   assign m_toXmit_o = m_strobe_o ? tx_arr[gidx_q] : last_tx_q;

   // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         gidx_q     <= '0;
         grant_o    <= '0;
         rem_q      <= '0;
         ss_q       <= '0;
         last_ss_q  <= '0;
         last_tx_q  <= '0;
         wd_q       <= '0;
         gap_q      <= '0;
         abort_q    <= 1'b0;
         rx_data_o  <= '0;
         rx_valid_o <= '0;
      end else begin
         state_q    <= state_d;
         rx_valid_o <= '0;
         gap_q      <= (state_q == S_GAP) ? gap_q + 8'd1 : 8'd0;
         case (state_q)
            S_IDLE: if (arb_valid) begin
               grant_o <= arb_gnt;
               gidx_q  <= arb_idx;
               rem_q   <= len_to_count(len_arr[arb_idx]);
               ss_q    <= ss_arr[arb_idx];
               abort_q <= 1'b0;
            end
            S_LOAD: begin
               wd_q      <= '0;
               last_ss_q <= ss_q;
               last_tx_q <= tx_arr[gidx_q];
            end
            S_WAIT: begin
               if (wd_q != '1) wd_q <= wd_q + 1'b1;
               if (m_ready_i) begin
                  rx_data_o  <= m_rcvd_i;
                  rx_valid_o <= grant_o;
                  rem_q      <= rem_q - 1'b1;
               end else if (wd_hit) begin
                  abort_q <= 1'b1;
               end
            end
            S_DONE: begin
               ptr_q   <= (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
               grant_o <= '0;
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   // The engine must be idle whenever a new byte may be handed to it.
   busy_when_idle_a: assert property (@(posedge Clk_i) disable iff (!Rst_ni)
      !(m_busy_i && (state_q == S_IDLE || state_q == S_LOAD)));
`endif

endmodule

// File: tb/tb_spi_sequencer.sv
// Randomized bench for spi_sequencer: a slave engine model, an event monitor and a
// transfer-level reference model (round-robin order, byte stream, spec timing).
module tb_spi_sequencer;

   localparam int          NREQ  = 4;
   localparam logic [7:0]  GAP_C = 8'd2;
   localparam logic [15:0] TMO_C = 16'd50;

   logic        Clk_i = 1'b0;
   logic        Rst_ni;
   logic [3:0]  req_i;
   logic [15:0] len_i;
   logic [7:0]  ss_i;
   logic [31:0] tx_data_i;
   logic [3:0]  tx_pop_o, grant_o, rx_valid_o, done_o, err_o;
   logic [7:0]  rx_data_o;
   logic        m_strobe_o;
   logic [1:0]  m_ss_o;
   logic [7:0]  m_toXmit_o;
   logic        m_busy_i, m_ready_i;
   logic [7:0]  m_rcvd_i;

   spi_sequencer #(.NREQ(NREQ), .GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
      .Clk_i      (Clk_i),
      .Rst_ni     (Rst_ni),
      .req_i      (req_i),
      .len_i      (len_i),
      .ss_i       (ss_i),
      .tx_data_i  (tx_data_i),
      .tx_pop_o   (tx_pop_o),
      .grant_o    (grant_o),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .m_strobe_o (m_strobe_o),
      .m_ss_o     (m_ss_o),
      .m_toXmit_o (m_toXmit_o),
      .m_busy_i   (m_busy_i),
      .m_ready_i  (m_ready_i),
      .m_rcvd_i   (m_rcvd_i)
   );

   always #5 Clk_i = ~Clk_i;

   int cyc = 0;
   always @(posedge Clk_i) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
      logic [7:0] data;
      logic [1:0] ss;
      logic [3:0] aux;
   } ev_t;

   ev_t ev_grant[$], ev_stb[$], ev_rx[$], ev_done[$];
   int  ev_rdy[$];
   int  rd_g = 0, rd_s = 0, rd_r = 0, rd_d = 0, rd_y = 0;

   int         total = 0, bad = 0;
   bit         slave_en = 1'b1;
   logic [7:0] tx_mem [NREQ][256];
   logic [7:0] idx    [NREQ];
   logic [7:0] eidx   [NREQ];
   int         ptr_m = 0;
   logic [1:0] ss_m [NREQ];

   // Monitor: record every externally visible event with its cycle number.
   initial begin : monitor
      logic [3:0] prev_g;
      ev_t        e;
      prev_g = '0;
      forever begin
         @(negedge Clk_i);
         e = '{cyc: cyc, vec: '0, data: '0, ss: '0, aux: '0};
         if (grant_o != 0 && prev_g == 0) begin
            e.vec = grant_o;
            ev_grant.push_back(e);
         end
         prev_g = grant_o;
         if (m_strobe_o || tx_pop_o != 0) begin
            e.vec = tx_pop_o; e.data = m_toXmit_o; e.ss = m_ss_o; e.aux = {3'b0, m_strobe_o};
            ev_stb.push_back(e);
         end
         if (rx_valid_o != 0) begin
            e.vec = rx_valid_o; e.data = rx_data_o; e.ss = '0; e.aux = '0;
            ev_rx.push_back(e);
         end
         if (done_o != 0 || err_o != 0) begin
            e.vec = done_o; e.data = '0; e.ss = '0; e.aux = err_o;
            ev_done.push_back(e);
         end
      end
   end

   // Slave engine: answers each strobe after 1..4 cycles with tx ^ 8'h99.
   initial begin : slave
      int         lat;
      logic [7:0] b;
      m_ready_i = 1'b0;
      m_busy_i  = 1'b0;
      m_rcvd_i  = '0;
      forever begin
         @(negedge Clk_i);
         m_ready_i = 1'b0;
         if (slave_en && Rst_ni && m_strobe_o) begin
            b   = m_toXmit_o;
            lat = $urandom_range(1, 4);
            for (int j = 1; j < lat; j++) begin
               @(negedge Clk_i);
               m_busy_i = 1'b1;
            end
            @(negedge Clk_i);
            m_busy_i  = 1'b0;
            m_ready_i = 1'b1;
            m_rcvd_i  = b ^ 8'h99;
            ev_rdy.push_back(cyc);
         end
      end
   end

   // Client data feeders: present tx_mem[c][idx[c]] and advance on each pop.
   initial begin : feeder
      logic [3:0] p;
      for (int c = 0; c < NREQ; c++) idx[c] = '0;
      forever begin
         for (int c = 0; c < NREQ; c++) tx_data_i[c*8 +: 8] = tx_mem[c][idx[c]];
         @(negedge Clk_i);
         p = tx_pop_o;
         @(posedge Clk_i);
         #1;
         for (int c = 0; c < NREQ; c++) if (p[c]) idx[c] = idx[c] + 8'd1;
      end
   end

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   task automatic set_client(input int c, input logic [3:0] len, input logic [1:0] ss);
      len_i[c*4 +: 4] = len;
      ss_i[c*2 +: 2]  = ss;
      ss_m[c]         = ss;
   endtask

   task automatic wait_dones(input int n, input int budget, input string name);
      int seen;
      int k;
      seen = 0;
      k    = 0;
      while (seen < n && k < budget) begin
         @(negedge Clk_i);
         k++;
         if (done_o != 0) begin
            seen++;
            req_i = req_i & ~done_o;
         end
      end
      total++;
      if (seen < n) begin
         bad++;
         $display("FAIL %s_budget: saw %0d done pulses, required %0d", name, seen, n);
      end
      #1;
   endtask

   // Check one transfer's recorded events against the spec-level expectation.
   task automatic verify_xfer(input int cli, input int n, input int exp_g, input bit tmo,
                              output int d_cyc);
      ev_t        g, s, r, d;
      logic [3:0] oh;
      logic [7:0] eb;
      int         prev_rdy, exp_c;
      oh    = 4'b0001 << cli;
      d_cyc = -1;
      total++;
      if (rd_g >= ev_grant.size()) begin
         bad++; $display("FAIL grant_missing: client %0d never granted", cli); return;
      end
      g = ev_grant[rd_g++];
      if (g.vec !== oh) begin
         bad++; $display("FAIL grant_vec: got %b required %b", g.vec, oh);
      end
      if (exp_g >= 0) begin
         total++;
         if (g.cyc != exp_g) begin
            bad++; $display("FAIL grant_cycle: got %0d required %0d", g.cyc, exp_g);
         end
      end
      prev_rdy = 0;
      s = g;
      for (int k = 0; k < (tmo ? 1 : n); k++) begin
         eb = tx_mem[cli][eidx[cli]];
         eidx[cli] = eidx[cli] + 8'd1;
         total++;
         if (rd_s >= ev_stb.size()) begin
            bad++; $display("FAIL strobe_missing: client %0d byte %0d", cli, k); return;
         end
         s = ev_stb[rd_s++];
         if ({s.aux[0], s.vec, s.ss, s.data} !== {1'b1, oh, ss_m[cli], eb}) begin
            bad++;
            $display("FAIL strobe_fields: client %0d byte %0d got stb=%b pop=%b ss=%0d tx=%h required stb=1 pop=%b ss=%0d tx=%h",
                     cli, k, s.aux[0], s.vec, s.ss, s.data, oh, ss_m[cli], eb);
         end
         exp_c = (k == 0) ? g.cyc : prev_rdy + 1 + int'(GAP_C);
         total++;
         if (s.cyc != exp_c) begin
            bad++; $display("FAIL strobe_cycle: client %0d byte %0d got %0d required %0d", cli, k, s.cyc, exp_c);
         end
         if (!tmo) begin
            total++;
            if (rd_y >= ev_rdy.size() || rd_r >= ev_rx.size()) begin
               bad++; $display("FAIL rx_missing: client %0d byte %0d", cli, k); return;
            end
            prev_rdy = ev_rdy[rd_y++];
            r = ev_rx[rd_r++];
            if (r.cyc != prev_rdy + 1 || r.vec !== oh || r.data !== (eb ^ 8'h99)) begin
               bad++;
               $display("FAIL rx_byte: client %0d byte %0d got cyc=%0d vec=%b data=%h required cyc=%0d vec=%b data=%h",
                        cli, k, r.cyc, r.vec, r.data, prev_rdy + 1, oh, eb ^ 8'h99);
            end
         end
      end
      total++;
      if (rd_d >= ev_done.size()) begin
         bad++; $display("FAIL done_missing: client %0d", cli); return;
      end
      d = ev_done[rd_d++];
      exp_c = tmo ? s.cyc + int'(TMO_C) + 1 : prev_rdy + 1;
      if (d.cyc != exp_c || d.vec !== oh || d.aux !== (tmo ? oh : 4'b0000)) begin
         bad++;
         $display("FAIL done_pulse: client %0d got cyc=%0d done=%b err=%b required cyc=%0d done=%b err=%b",
                  cli, d.cyc, d.vec, d.aux, exp_c, oh, tmo ? oh : 4'b0000);
      end
      if (tmo) begin
         total++;
         if (ev_rx.size() != rd_r) begin
            bad++; $display("FAIL rx_during_abort: got %0d rx pulses required 0", ev_rx.size() - rd_r);
         end
      end
      ptr_m = (cli + 1) % NREQ;
      d_cyc = d.cyc;
   endtask

   // Raise a set of requests together and check every resulting transfer in model order.
   task automatic run_chain(input logic [3:0] r, input string name);
      logic [3:0] pend;
      int         c, exp_g, d, n, cnt;
      pend = r;
      cnt  = 0;
      for (int i = 0; i < NREQ; i++) if (r[i]) cnt++;
      @(negedge Clk_i);
      exp_g = cyc + 1;
      req_i = r;
      wait_dones(cnt, 3000, name);
      while (pend != 0) begin
         c = pick(pend, ptr_m);
         n = (len_i[c*4 +: 4] == 0) ? 16 : int'(len_i[c*4 +: 4]);
         verify_xfer(c, n, exp_g, 1'b0, d);
         pend[c] = 1'b0;
         exp_g = d + 2;
      end
   endtask

   task automatic test_reset();
      Rst_ni = 1'b0;
      repeat (3) @(negedge Clk_i);
      total++;
      if ({grant_o, tx_pop_o, rx_valid_o, done_o, err_o, m_strobe_o, m_ss_o, m_toXmit_o, rx_data_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got gnt=%b pop=%b rxv=%b done=%b err=%b stb=%b ss=%0d tx=%h rx=%h required all 0",
                  grant_o, tx_pop_o, rx_valid_o, done_o, err_o, m_strobe_o, m_ss_o, m_toXmit_o, rx_data_o);
      end
      Rst_ni = 1'b1;
      repeat (2) @(negedge Clk_i);
      total++;
      if (grant_o !== 4'b0000 || m_strobe_o !== 1'b0) begin
         bad++; $display("FAIL idle_no_request: got gnt=%b stb=%b required 0", grant_o, m_strobe_o);
      end
   endtask

   task automatic test_single_byte();
      set_client(0, 4'd1, 2'd1);
      tx_mem[0][eidx[0]] = 8'hA5;
      run_chain(4'b0001, "single");
      @(negedge Clk_i);
      total++;
      if (rx_data_o !== 8'h3C || m_toXmit_o !== 8'hA5 || m_ss_o !== 2'd1 || m_strobe_o !== 1'b0) begin
         bad++;
         $display("FAIL single_hold: got rx=%h tx=%h ss=%0d stb=%b required rx=3c tx=a5 ss=1 stb=0",
                  rx_data_o, m_toXmit_o, m_ss_o, m_strobe_o);
      end
   endtask

   task automatic test_len0();
      set_client(1, 4'd0, 2'($urandom_range(0, 3)));
      run_chain(4'b0010, "len0");
   endtask

   task automatic test_multi_gap();
      set_client(2, 4'd3, 2'd3);
      run_chain(4'b0100, "gap");
      total++;
      if (ev_stb.size() != rd_s || ev_rx.size() != rd_r) begin
         bad++;
         $display("FAIL gap_extra: got %0d extra pops and %0d extra rx pulses required 0",
                  ev_stb.size() - rd_s, ev_rx.size() - rd_r);
      end
   endtask

   task automatic test_timeout();
      int d;
      set_client(3, 4'd2, 2'd2);
      @(negedge Clk_i);
      slave_en = 1'b0;
      d = cyc + 1;
      req_i = 4'b1000;
      wait_dones(1, 200, "timeout");
      verify_xfer(3, 2, d, 1'b1, d);
      slave_en = 1'b1;
      @(negedge Clk_i);
      total++;
      if (grant_o !== 4'b0000 || m_strobe_o !== 1'b0) begin
         bad++; $display("FAIL timeout_idle: got gnt=%b stb=%b required 0", grant_o, m_strobe_o);
      end
   endtask

   task automatic test_fairness();
      for (int c = 0; c < NREQ; c++) set_client(c, 4'd1, 2'(c));
      total++;
      if (ptr_m != 0) begin
         bad++; $display("FAIL fair_start: model pointer %0d required 0", ptr_m);
      end
      run_chain(4'b1111, "fair1");
      run_chain(4'b1111, "fair2");
   endtask

   task automatic test_random();
      logic [3:0] r;
      for (int it = 0; it < 8; it++) begin
         for (int c = 0; c < NREQ; c++)
            set_client(c, ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 4)),
                       2'($urandom_range(0, 3)));
         r = 4'($urandom_range(1, 15));
         run_chain(r, "random");
      end
   endtask

   task automatic test_reset_mid();
      int k;
      set_client(0, 4'd1, 2'd0);
      run_chain(4'b0001, "pre_reset");
      set_client(2, 4'd4, 2'd1);
      @(negedge Clk_i);
      slave_en = 1'b0;
      req_i = 4'b0100;
      k = 0;
      while (!m_strobe_o && k < 20) begin
         @(negedge Clk_i);
         k++;
      end
      total++;
      if (!m_strobe_o) begin
         bad++; $display("FAIL mid_no_strobe: got stb=0 required 1");
      end
      repeat (3) @(negedge Clk_i);
      Rst_ni = 1'b0;
      #1;
      total++;
      if ({grant_o, tx_pop_o, rx_valid_o, done_o, err_o, m_strobe_o, m_ss_o, m_toXmit_o, rx_data_o} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got gnt=%b pop=%b rxv=%b done=%b err=%b stb=%b ss=%0d tx=%h rx=%h required all 0",
                  grant_o, tx_pop_o, rx_valid_o, done_o, err_o, m_strobe_o, m_ss_o, m_toXmit_o, rx_data_o);
      end
      req_i = 4'b0000;
      repeat (2) @(negedge Clk_i);
      Rst_ni = 1'b1;
      repeat (2) @(negedge Clk_i);
      #1;
      // The aborted transfer left one grant, one consumed byte and no done pulse.
      total++;
      if (ev_grant.size() != rd_g + 1 || ev_stb.size() != rd_s + 1 || ev_done.size() != rd_d) begin
         bad++;
         $display("FAIL mid_events: got grants=%0d strobes=%0d dones=%0d required 1 1 0",
                  ev_grant.size() - rd_g, ev_stb.size() - rd_s, ev_done.size() - rd_d);
      end
      rd_g = ev_grant.size();
      rd_s = ev_stb.size();
      eidx[2] = eidx[2] + 8'd1;
      ptr_m = 0;
      slave_en = 1'b1;
      set_client(0, 4'd2, 2'd2);
      set_client(3, 4'd2, 2'd3);
      run_chain(4'b1001, "post_reset");
   endtask

   task automatic test_no_stray();
      repeat (5) @(negedge Clk_i);
      #1;
      total++;
      if (ev_grant.size() != rd_g || ev_stb.size() != rd_s || ev_rx.size() != rd_r || ev_done.size() != rd_d) begin
         bad++;
         $display("FAIL stray_events: got extra grants=%0d strobes=%0d rx=%0d dones=%0d required 0",
                  ev_grant.size() - rd_g, ev_stb.size() - rd_s, ev_rx.size() - rd_r, ev_done.size() - rd_d);
      end
   endtask

   initial begin
      req_i  = '0;
      len_i  = '0;
      ss_i   = '0;
      Rst_ni = 1'b0;
      for (int c = 0; c < NREQ; c++) begin
         eidx[c] = '0;
         ss_m[c] = '0;
         for (int i = 0; i < 256; i++) tx_mem[c][i] = 8'($urandom);
      end
      test_reset();
      test_single_byte();
      test_len0();
      test_multi_gap();
      test_timeout();
      test_fairness();
      test_random();
      test_reset_mid();
      test_no_stray();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
